// File: rtl/upcnt_timer_if.sv
// upcnt_timer control/status bundle.
// Timer side is the slave; the controlling logic is the master.
interface upcnt_timer_if #(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
);
  logic                 ci;
  logic                 ld;
  logic [WIDTH-1:0]     d;
  logic                 pre_wr;
  logic [PRE_WIDTH-1:0] pre_d;
  logic                 cmp_wr;
  logic [WIDTH-1:0]     cmp_d;
  logic                 mode;
  logic                 start;
  logic                 stop;
  logic [WIDTH-1:0]     q;
  logic                 co;
  logic                 match;
  logic                 running;

  modport master (
    output ci, ld, d, pre_wr, pre_d,
    output cmp_wr, cmp_d, mode, start, stop,
    input  q, co, match, running
  );

  modport slave (
    input  ci, ld, d, pre_wr, pre_d,
    input  cmp_wr, cmp_d, mode, start, stop,
    output q, co, match, running
  );
endinterface

// File: rtl/upcnt_timer.sv
// Prescaled up-counting interval timer with compare match,
// free-run / one-shot modes and cascade carry.
module upcnt_timer #(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
) (
  input logic          clk,
  input logic          resl,
  upcnt_timer_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state;
  state_t               state_nx;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     q_nx;
  logic [WIDTH-1:0]     cmp_reg;
  logic [PRE_WIDTH-1:0] pre_cnt;
  logic [PRE_WIDTH-1:0] pre_nx;
  logic [PRE_WIDTH-1:0] pre_reg;
  logic                 match;
  logic                 running;
  logic                 tick;
  logic                 adv;
  logic                 hit;

  assign running = (state == RUN);
  assign tick    = running & bus.ci & (pre_cnt == pre_reg);
  // load and a re-start both freeze q for this edge
  assign adv     = tick & ~bus.ld & ~bus.start;
  assign hit     = adv & (q == cmp_reg);

  assign bus.q       = q;
  assign bus.match   = match;
  assign bus.running = running;
  assign bus.co      = bus.ci & running & tick & (&q);

  always_comb begin
    state_nx = state;
    q_nx     = q;
    pre_nx   = pre_cnt;
    if (bus.stop)
      state_nx = IDLE;
    else if (bus.start)
      state_nx = RUN;
    else if (hit & bus.mode)
      state_nx = IDLE;
    if (bus.ld)
      q_nx = bus.d;
    else if (adv)
      q_nx = hit ? '0 : q + 1'b1;
    if (bus.ld | bus.start)
      pre_nx = '0;
    else if (running & bus.ci)
      pre_nx = tick ? '0 : pre_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      state   <= IDLE;
      q       <= '0;
      pre_cnt <= '0;
      pre_reg <= '0;
      cmp_reg <= '1;
      match   <= 1'b0;
    end else begin
      state   <= state_nx;
      q       <= q_nx;
      pre_cnt <= pre_nx;
      match   <= hit;
      if (bus.pre_wr)
        pre_reg <= bus.pre_d;
      if (bus.cmp_wr)
        cmp_reg <= bus.cmp_d;
    end
  end
endmodule

// File: tb/tb_upcnt_timer.sv
// Self-checking bench for upcnt_timer: vector table, directed
// corner sequences and randomized traffic against a reference model.
module tb_upcnt_timer;
  localparam int W  = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic resl;
  always #5 clk = ~clk;

  upcnt_timer_if #(.WIDTH(W), .PRE_WIDTH(PW)) bus ();

  upcnt_timer #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
    .clk  (clk),
    .resl (resl),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_q, m_pre, m_prereg, m_cmp;
  bit m_run, m_match;

  typedef struct {
    bit          ld;
    logic [15:0] d;
    bit          start;
    bit          stop;
    bit          ci;
    logic [15:0] eq;
    bit          erun;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_q = 0; m_pre = 0; m_prereg = 0; m_cmp = 65535;
    m_run = 0; m_match = 0;
  endtask

  task automatic clr_strobes();
    bus.ld = 0; bus.start = 0; bus.stop = 0;
    bus.pre_wr = 0; bus.cmp_wr = 0;
  endtask

  // one clock: called at negedge with inputs already set
  task automatic cyc();
    bit tick, adv, hit, nrun, pw, cw;
    int nq, npre, pd, cd;
    #1;
    tick = m_run && bus.ci && (m_pre == m_prereg);
    chk("co", 32'(bus.co), 32'(tick && m_q == 65535));
    adv = tick && !bus.ld && !bus.start;
    hit = adv && (m_q == m_cmp);
    if (bus.ld)       nq = int'(bus.d);
    else if (hit)     nq = 0;
    else if (adv)     nq = (m_q + 1) % 65536;
    else              nq = m_q;
    if (bus.ld || bus.start)  npre = 0;
    else if (m_run && bus.ci) npre = tick ? 0 : m_pre + 1;
    else                      npre = m_pre;
    if (bus.stop)              nrun = 0;
    else if (bus.start)        nrun = 1;
    else if (hit && bus.mode)  nrun = 0;
    else                       nrun = m_run;
    pw = bus.pre_wr; pd = int'(bus.pre_d);
    cw = bus.cmp_wr; cd = int'(bus.cmp_d);
    @(posedge clk);
    m_q = nq; m_pre = npre; m_run = nrun; m_match = hit;
    if (pw) m_prereg = pd;
    if (cw) m_cmp = cd;
    @(negedge clk);
    chk("q", 32'(bus.q), 32'(m_q));
    chk("running", 32'(bus.running), 32'(m_run));
    chk("match", 32'(bus.match), 32'(m_match));
    clr_strobes();
  endtask

  task automatic setup(input int p, input int c, input bit md);
    bus.stop = 1; bus.pre_wr = 1; bus.pre_d = PW'(p);
    bus.cmp_wr = 1; bus.cmp_d = W'(c); bus.mode = md;
    cyc();
  endtask

  initial begin
    resl = 0;
    bus.ci = 0; bus.mode = 0; bus.d = '0;
    bus.pre_d = '0; bus.cmp_d = '0;
    clr_strobes();
    m_reset();
    tbl[0] = '{1, 16'd5,   0, 0, 0, 16'd5,   0};
    tbl[1] = '{0, 16'd0,   1, 0, 1, 16'd5,   1};
    tbl[2] = '{0, 16'd0,   0, 0, 1, 16'd6,   1};
    tbl[3] = '{0, 16'd0,   0, 0, 0, 16'd6,   1};
    tbl[4] = '{1, 16'd100, 0, 0, 1, 16'd100, 1};
    tbl[5] = '{0, 16'd0,   0, 1, 1, 16'd101, 0};
    tbl[6] = '{0, 16'd0,   1, 1, 1, 16'd101, 0};
    tbl[7] = '{0, 16'd0,   0, 0, 1, 16'd101, 0};

    repeat (2) @(negedge clk);
    chk("rst_q", 32'(bus.q), 0);
    chk("rst_running", 32'(bus.running), 0);
    chk("rst_match", 32'(bus.match), 0);
    chk("rst_co", 32'(bus.co), 0);
    resl = 1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      bus.ld = tbl[i].ld; bus.d = tbl[i].d;
      bus.start = tbl[i].start; bus.stop = tbl[i].stop;
      bus.ci = tbl[i].ci;
      cyc();
      chk("tbl_q", 32'(bus.q), 32'(tbl[i].eq));
      chk("tbl_running", 32'(bus.running), 32'(tbl[i].erun));
      chk("tbl_match", 32'(bus.match), 0);
    end

    // async reset mid-count
    bus.ci = 1; bus.start = 1; cyc();
    bus.ld = 1; bus.d = 16'h1234; cyc();
    chk("pre_rst_q", 32'(bus.q), 32'h1234);
    #2 resl = 0;
    #1;
    chk("async_q", 32'(bus.q), 0);
    chk("async_running", 32'(bus.running), 0);
    chk("async_match", 32'(bus.match), 0);
    m_reset();
    clr_strobes();
    @(negedge clk);
    resl = 1;

    // wrap/carry with reset compare value
    bus.ci = 1; bus.mode = 0;
    bus.ld = 1; bus.d = 16'hFFFE; bus.start = 1; cyc();
    cyc();
    chk("wrap_q", 32'(bus.q), 32'hFFFF);
    #1 chk("wrap_co", 32'(bus.co), 1);
    cyc();
    chk("wrap_q0", 32'(bus.q), 0);
    chk("wrap_match", 32'(bus.match), 1);

    // free-run, P=3, C=4
    setup(3, 4, 0);
    bus.ld = 1; bus.d = '0; cyc();
    bus.start = 1; cyc();
    for (int k = 1; k <= 60; k++) begin
      cyc();
      chk("fr_q", 32'(bus.q), 32'((k / 4) % 5));
      chk("fr_match", 32'(bus.match), 32'(k % 20 == 0));
    end

    // one-shot, L=10, C=12, P=0
    setup(0, 12, 1);
    bus.ld = 1; bus.d = 16'd10; bus.start = 1; cyc();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("os_q", 32'(bus.q), k < 3 ? 32'(10 + k) : 0);
      chk("os_match", 32'(bus.match), 32'(k == 3));
      chk("os_running", 32'(bus.running), 32'(k < 3));
    end

    // compare write on the hit cycle uses the old value
    setup(0, 3, 0);
    bus.ld = 1; bus.d = '0; bus.start = 1; cyc();
    repeat (3) cyc();
    chk("cw_q3", 32'(bus.q), 3);
    bus.cmp_wr = 1; bus.cmp_d = 16'd10; cyc();
    chk("cw_q", 32'(bus.q), 0);
    chk("cw_match", 32'(bus.match), 1);

    // ci gating, P=1, ci toggling
    setup(1, 65535, 0);
    bus.ci = 0; bus.ld = 1; bus.d = '0; bus.start = 1; cyc();
    for (int k = 1; k <= 16; k++) begin
      bus.ci = (k % 2 == 1);
      cyc();
      chk("ci_q", 32'(bus.q), 32'(((k + 1) / 2) / 2));
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.ci = ($urandom_range(0, 3) != 0);
      bus.ld = ($urandom_range(0, 19) == 0);
      bus.d = ($urandom_range(0, 3) == 0) ?
              W'(16'hFFF0 + $urandom_range(0, 15)) :
              W'($urandom_range(0, 39));
      bus.start = ($urandom_range(0, 14) == 0);
      bus.stop = ($urandom_range(0, 24) == 0);
      bus.pre_wr = ($urandom_range(0, 29) == 0);
      bus.pre_d = PW'($urandom_range(0, 3));
      bus.cmp_wr = ($urandom_range(0, 29) == 0);
      bus.cmp_d = ($urandom_range(0, 4) == 0) ? 16'hFFFF :
                  W'($urandom_range(0, 39));
      if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/upcnt_timer.md
# upcnt_timer

Loadable, prescaled up-counting interval timer with compare-match and cascade carry; the count-up counterpart of the down-counter bit cells used in TOM's timing logic. An N-bit counter advances from a loaded value toward a programmable compare value and signals completion. It runs in free-run (auto-restart) or one-shot mode. It sits beside the object/blitter timing logic as a general event timer and can be chained through `ci`/`co` to build wider counters.

## Interface
Parameters:
- `WIDTH`, 16: counter and compare width
- `PRE_WIDTH`, 8: prescaler width

Ports:
- `clk`  in  1  system clock; single clock domain, rising-edge
- `resl`  in  1  reset; asynchronous, active-low
- `ci`  in  1  count enable / carry-in from lower stage; prescaler advances only when high
- `ld`  in  1  load strobe: `q <= d`, prescaler cleared
- `d`  in  WIDTH  load value
- `pre_wr`  in  1  write prescaler reload register from `pre_d`
- `pre_d`  in  PRE_WIDTH  prescaler divide value P (tick every P+1 enabled cycles)
- `cmp_wr`  in  1  write compare register from `cmp_d`
- `cmp_d`  in  WIDTH  compare value C
- `mode`  in  1  0 = free-run, 1 = one-shot
- `start`  in  1  enter RUN, prescaler cleared
- `stop`  in  1  enter IDLE
- `q`  out  WIDTH  current count (registered)
- `co`  out  1  carry-out, combinational: `ci & running & tick & (q == all-ones)`
- `match`  out  1  registered one-cycle pulse on compare hit
- `running`  out  1  high in RUN

## Operation
- Registers: `q`, `pre_cnt`, `pre_reg`, `cmp_reg`, `running`, `match`.
- States: IDLE (`running`=0) and RUN (`running`=1).
  - IDLE -> RUN on `start`.
  - RUN -> IDLE on `stop`.
  - RUN -> IDLE on a compare hit when `mode`=1.
- `tick` = `running & ci & (pre_cnt == pre_reg)`.
- In RUN with `ci`=1:
  - If `pre_cnt == pre_reg`: `pre_cnt <= 0`.
  - Otherwise `pre_cnt <= pre_cnt + 1`.
  - `pre_cnt` holds when `ci`=0 or in IDLE.
- On `tick`:
  - If `q == cmp_reg` (compare hit): `q <= 0`, `match <= 1` next cycle.
  - Otherwise `q <= q + 1`, modulo 2^WIDTH; all-ones wraps to 0 with `co` high that cycle.
- `match` is 1 for exactly one cycle per hit and 0 otherwise.
- Priority, highest first:
  - `ld` over tick: `q <= d`, `pre_cnt <= 0`, no hit evaluated that cycle.
  - `stop` over `start`: both high leaves IDLE, or forces IDLE.
  - `start` while already in RUN clears `pre_cnt` only; `q` is unchanged.
- `pre_wr`/`cmp_wr` update their registers at the clock edge. Comparisons on that same edge use the old value; the new value applies from the next cycle.
- `ld` is honoured in both IDLE and RUN. `q` holds in IDLE except on load.
- `resl` low at any time, including mid-count:
  - `q`=0, `pre_cnt`=0, `pre_reg`=0, `cmp_reg`=all-ones, `running`=0, `match`=0.
  - Outputs take these values immediately, without waiting for `clk`.

## Timing
- Reset values: `q`=0, `match`=0, `running`=0, `co`=0.
- `running` rises one cycle after the `start` edge.
- First increment occurs after P+1 enabled (`ci`=1) cycles in RUN.
- With `ci` held high, load value L and L ≤ C:
  - A compare hit occurs (C−L+1)·(P+1) cycles after RUN entry.
  - Free-run period is (C+1)·(P+1) cycles.
- In one-shot mode:
  - `running` falls on the same edge that sets `match`.
  - `q` reads 0 afterwards.
- `co` is combinational from registered state and `ci`. It is valid in the same cycle, so a chained stage's `ci` sees it before the next edge.
- No handshakes; all strobes are single-cycle level samples.

## Test plan
- Reset:
  - Assert `resl`=0 mid-run with `q`=0x1234 -> `q`=0, `running`=0, `match`=0 immediately.
  - After release, `cmp_reg` behaves as 0xFFFF.
- Prescale and free-run:
  - Set P=3, C=4, `mode`=0, `ci`=1, then `start` -> `q` steps 0,1,2,3,4 every 4 cycles.
  - `match` pulses once every 20 cycles and `q` returns to 0.
- One-shot:
  - Set `mode`=1, `ld` with `d`=10, C=12, P=0, `start` -> `match` pulses 3 cycles after RUN entry.
  - `running` falls with it and `q` holds 0.
- Wrap and carry:
  - Set C=0xFFFF, `ld` with `d`=0xFFFE, P=0, `start` -> `co`=1 in the cycle `q`=0xFFFF.
  - `match` pulses next cycle and `q`=0.
- Priority:
  - Raise `ld` (`d`=5) on a tick cycle -> `q`=5, no increment.
  - Raise `start` and `stop` together -> stays IDLE.
  - Assert `cmp_wr` on the hit cycle -> old compare value is used.
- `ci` gating:
  - Toggle `ci` 1/0 with P=1 -> increments every 4 clocks.
  - Prescaler holds while `ci`=0.
